// File: rtl/reg_file_mp_pkg.sv
// reg_file_mp_pkg: shared defaults, clear-FSM state encoding and sizing helper
// for the multi-port register file.
//   RF_DEF_*     default widths/counts for the light_rv32i integer file
//   rf_state_e   clear engine states (IDLE=0, CLEAR=1)
//   rf_cnt_width sweep-counter width, never below 1 bit
package reg_file_mp_pkg;

    localparam int RF_DEF_ADDR_WIDTH = 5;
    localparam int RF_DEF_DATA_WIDTH = 32;
    localparam int RF_DEF_REG_NUMBER = 32;
    localparam int RF_DEF_RD_PORTS   = 2;
    localparam int RF_DEF_WR_PORTS   = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } rf_state_e;

    function automatic int rf_cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg_file_mp_scoreboard.sv
// rf_scoreboard: per-register pending (busy) bits for RAW hazard detection.
//   i_WrHit    decoded write enables, one per register (clears busy)
//   i_SetHit   decoded scoreboard set, one per register (set beats clear)
//   i_SweepEn  clear engine active; i_SweepIdx register zeroed this cycle
//   i_RdAddr   packed read addresses; o_RdBusy per-port busy lookup
// Decoded hits arrive already gated by IDLE, address range and the zero
// register, so this block only applies priority and lookup.
module rf_scoreboard #(
    parameter int ADDR_WIDTH = 5,
    parameter int REG_NUMBER = 32,
    parameter int RD_PORTS   = 2,
    parameter int CNT_W      = 5
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [REG_NUMBER-1:0]          i_WrHit,
    input  logic [REG_NUMBER-1:0]          i_SetHit,
    input  logic                           i_SweepEn,
    input  logic [CNT_W-1:0]               i_SweepIdx,
    input  logic [RD_PORTS*ADDR_WIDTH-1:0] i_RdAddr,
    output logic [RD_PORTS-1:0]            o_RdBusy
);

    logic [REG_NUMBER-1:0] r_busy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy <= '0;
        end else begin
            for (int r = 0; r < REG_NUMBER; r++) begin
                if (i_SweepEn && i_SweepIdx == CNT_W'(r))
                    r_busy[r] <= 1'b0;
                else
                    r_busy[r] <= i_SetHit[r] | (r_busy[r] & ~i_WrHit[r]);
            end
        end
    end

    // A write landing this cycle hides the busy bit unless a set re-arms it.
    // Addresses beyond the file match no register and read not-busy.
    always_comb begin
        o_RdBusy = '0;
        for (int k = 0; k < RD_PORTS; k++) begin
            for (int r = 0; r < REG_NUMBER; r++) begin
                if (i_RdAddr[k*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r))
                    o_RdBusy[k] = r_busy[r] & ~(i_WrHit[r] & ~i_SetHit[r]);
            end
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised multi-port register file with write priority
// (highest port wins), same-cycle write-to-read bypass, pending scoreboard
// and a sequential clear engine.
//   i_RdAddr/o_RdData/o_RdBusy  RD_PORTS combinational read ports
//   i_WrEn/i_WrAddr/i_WrData    WR_PORTS write ports
//   i_SbSetEn/i_SbSetAddr       mark a register pending
//   i_ClrReq                    start a full sweep; o_Ready low while sweeping
module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = RF_DEF_DATA_WIDTH,
    parameter int REG_NUMBER = RF_DEF_REG_NUMBER,
    parameter int RD_PORTS   = RF_DEF_RD_PORTS,
    parameter int WR_PORTS   = RF_DEF_WR_PORTS,
    parameter int ZERO_REG   = 1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [RD_PORTS*ADDR_WIDTH-1:0] i_RdAddr,
    output logic [RD_PORTS*DATA_WIDTH-1:0] o_RdData,
    output logic [RD_PORTS-1:0]            o_RdBusy,
    input  logic [WR_PORTS-1:0]            i_WrEn,
    input  logic [WR_PORTS*ADDR_WIDTH-1:0] i_WrAddr,
    input  logic [WR_PORTS*DATA_WIDTH-1:0] i_WrData,
    input  logic                           i_SbSetEn,
    input  logic [ADDR_WIDTH-1:0]          i_SbSetAddr,
    input  logic                           i_ClrReq,
    output logic                           o_Ready
);

    localparam int CNT_W = rf_cnt_width(REG_NUMBER);

    rf_state_e                             r_state, w_state_nxt;
    logic [CNT_W-1:0]                      r_cnt, w_cnt_nxt;
    logic [REG_NUMBER-1:0][DATA_WIDTH-1:0] r_regs;
    logic [REG_NUMBER-1:0][DATA_WIDTH-1:0] w_wr_data;
    logic [REG_NUMBER-1:0]                 w_wr_hit;
    logic [REG_NUMBER-1:0]                 w_set_hit;
    logic                                  w_idle;

    assign w_idle  = (r_state == ST_IDLE);
    assign o_Ready = w_idle;

    // Per-register decode. Walking ports in ascending order lets the highest
    // matching port overwrite lower ones. Register 0 (when hardwired) and
    // out-of-range addresses never match, so they need no separate guard.
    always_comb begin
        w_wr_hit  = '0;
        w_wr_data = '0;
        w_set_hit = '0;
        for (int r = 0; r < REG_NUMBER; r++) begin
            if (w_idle && !(ZERO_REG != 0 && r == 0)) begin
                for (int p = 0; p < WR_PORTS; p++) begin
                    if (i_WrEn[p] && i_WrAddr[p*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r)) begin
                        w_wr_hit[r]  = 1'b1;
                        w_wr_data[r] = i_WrData[p*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                if (i_SbSetEn && i_SbSetAddr == ADDR_WIDTH'(r))
                    w_set_hit[r] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_regs <= '0;
        end else begin
            for (int r = 0; r < REG_NUMBER; r++) begin
                if (!w_idle) begin
                    if (r_cnt == CNT_W'(r))
                        r_regs[r] <= '0;
                end else if (w_wr_hit[r]) begin
                    r_regs[r] <= w_wr_data[r];
                end
            end
        end
    end

    // Bypass falls out of the decode: w_wr_hit is only ever set in IDLE, and a
    // hardwired register 0 holds 0 in the array, so rule order is preserved.
    always_comb begin
        o_RdData = '0;
        for (int k = 0; k < RD_PORTS; k++) begin
            for (int r = 0; r < REG_NUMBER; r++) begin
                if (i_RdAddr[k*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r))
                    o_RdData[k*DATA_WIDTH +: DATA_WIDTH] = w_wr_hit[r] ? w_wr_data[r] : r_regs[r];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (i_ClrReq) begin
                    w_state_nxt = ST_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            ST_CLEAR: begin
                if (r_cnt == CNT_W'(REG_NUMBER - 1)) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    rf_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .REG_NUMBER (REG_NUMBER),
        .RD_PORTS   (RD_PORTS),
        .CNT_W      (CNT_W)
    ) u_sb (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_WrHit    (w_wr_hit),
        .i_SetHit   (w_set_hit),
        .i_SweepEn  (!w_idle),
        .i_SweepIdx (r_cnt),
        .i_RdAddr   (i_RdAddr),
        .o_RdBusy   (o_RdBusy)
    );

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed + randomised bench for reg_file_mp: a default 32x32 2R/2W file and
// a 16-entry 4R/3W file. Expected read results are queued when a read is set
// up and popped/compared once the combinational outputs have settled.
module tb_reg_file_mp;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // default instance
    logic [9:0]  rd_addr = '0;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [1:0]  wr_en = '0;
    logic [9:0]  wr_addr = '0;
    logic [63:0] wr_data = '0;
    logic        set_en = 1'b0;
    logic [4:0]  set_addr = '0;
    logic        clr = 1'b0;
    logic        ready;

    // 16-entry, 4 read / 3 write instance
    logic [19:0]  rd_addr2 = '0;
    logic [127:0] rd_data2;
    logic [3:0]   rd_busy2;
    logic [2:0]   wr_en2 = '0;
    logic [14:0]  wr_addr2 = '0;
    logic [95:0]  wr_data2 = '0;
    logic         set_en2 = 1'b0;
    logic [4:0]   set_addr2 = '0;
    logic         clr2 = 1'b0;
    logic         ready2;

    reg_file_mp dut (
        .clk(clk), .reset_n(reset_n),
        .i_RdAddr(rd_addr), .o_RdData(rd_data), .o_RdBusy(rd_busy),
        .i_WrEn(wr_en), .i_WrAddr(wr_addr), .i_WrData(wr_data),
        .i_SbSetEn(set_en), .i_SbSetAddr(set_addr),
        .i_ClrReq(clr), .o_Ready(ready)
    );

    reg_file_mp #(
        .ADDR_WIDTH(5), .DATA_WIDTH(32), .REG_NUMBER(16),
        .RD_PORTS(4), .WR_PORTS(3), .ZERO_REG(1)
    ) dut2 (
        .clk(clk), .reset_n(reset_n),
        .i_RdAddr(rd_addr2), .o_RdData(rd_data2), .o_RdBusy(rd_busy2),
        .i_WrEn(wr_en2), .i_WrAddr(wr_addr2), .i_WrData(wr_data2),
        .i_SbSetEn(set_en2), .i_SbSetAddr(set_addr2),
        .i_ClrReq(clr2), .o_Ready(ready2)
    );

    typedef struct {
        int          inst;
        int          port;
        logic [31:0] data;
        logic        busy;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    logic [31:0] mreg [16];
    logic        mbusy[16];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input int inst, input int port, input logic [31:0] d,
                        input logic b, input string tag);
        exp_t e;
        e.inst = inst; e.port = port; e.data = d; e.busy = b; e.tag = tag;
        q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            if (e.inst == 0) begin
                chk({e.tag, "_data"}, 64'(rd_data[e.port*32 +: 32]), 64'(e.data));
                chk({e.tag, "_busy"}, 64'(rd_busy[e.port]), 64'(e.busy));
            end else begin
                chk({e.tag, "_data"}, 64'(rd_data2[e.port*32 +: 32]), 64'(e.data));
                chk({e.tag, "_busy"}, 64'(rd_busy2[e.port]), 64'(e.busy));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic wr(input int p, input int a, input logic [31:0] d);
        wr_en[p] = 1'b1;
        wr_addr[p*5 +: 5] = 5'(a);
        wr_data[p*32 +: 32] = d;
    endtask

    task automatic rd(input int p, input int a);
        rd_addr[p*5 +: 5] = 5'(a);
    endtask

    task automatic idle_in();
        wr_en = '0; set_en = 1'b0; clr = 1'b0;
    endtask

    initial begin
        int lowcnt;
        // ---------------- reset ----------------
        rd(0, 5); rd(1, 31);
        #3;
        chk("rst_ready", 64'(ready), 64'd1);
        push(0, 0, 32'h0, 1'b0, "rst_p0");
        push(0, 1, 32'h0, 1'b0, "rst_p1");
        drain();
        tick();
        reset_n = 1'b1;
        tick();

        // ---------------- zero register ----------------
        wr(0, 0, 32'hDEAD); rd(0, 0); rd(1, 0);
        settle();
        push(0, 0, 32'h0, 1'b0, "x0_byp");
        drain();
        tick(); idle_in();
        settle();
        push(0, 1, 32'h0, 1'b0, "x0_arr");
        drain();
        tick();

        // ---------------- write priority + bypass ----------------
        wr(0, 5, 32'h11); wr(1, 5, 32'h22); rd(0, 5); rd(1, 6);
        settle();
        push(0, 0, 32'h22, 1'b0, "prio_byp");
        push(0, 1, 32'h0, 1'b0, "prio_other");
        drain();
        tick(); idle_in();
        settle();
        push(0, 0, 32'h22, 1'b0, "prio_arr");
        drain();
        tick();

        // ---------------- scoreboard ----------------
        set_en = 1'b1; set_addr = 5'd7; rd(0, 7);
        settle();
        push(0, 0, 32'h0, 1'b0, "sb_set_same");
        drain();
        tick(); idle_in();
        settle();
        push(0, 0, 32'h0, 1'b1, "sb_set_next");
        drain();
        wr(0, 7, 32'h77);
        settle();
        push(0, 0, 32'h77, 1'b0, "sb_wrclr_same");
        drain();
        tick(); idle_in();
        settle();
        push(0, 0, 32'h77, 1'b0, "sb_wrclr_next");
        drain();
        tick();
        set_en = 1'b1; set_addr = 5'd7;
        tick();
        set_en = 1'b1; set_addr = 5'd7; wr(1, 7, 32'h78);
        settle();
        push(0, 0, 32'h78, 1'b1, "sb_setwin_same");
        drain();
        tick(); idle_in();
        settle();
        push(0, 0, 32'h78, 1'b1, "sb_setwin_next");
        drain();

        // ---------------- clear ----------------
        for (int i = 1; i < 32; i += 2) begin
            idle_in();
            wr(0, i, 32'(i));
            if (i + 1 < 32) wr(1, i + 1, 32'(i + 1));
            tick();
        end
        idle_in();
        rd(0, 17); rd(1, 30);
        settle();
        push(0, 0, 32'd17, 1'b0, "fill_x17");
        push(0, 1, 32'd30, 1'b0, "fill_x30");
        drain();
        // clear request together with a write and a set: both land, then get swept
        clr = 1'b1; wr(0, 2, 32'hAA); set_en = 1'b1; set_addr = 5'd30;
        tick();
        lowcnt = 0;
        for (int c = 0; c < 100; c++) begin
            idle_in();
            if (c == 1) begin wr(0, 3, 32'hFF); rd(0, 3); end
            if (c == 5) begin wr(1, 3, 32'hFF); rd(0, 3); rd(1, 20); end
            settle();
            if (ready) break;
            lowcnt++;
            if (c == 1) push(0, 0, 32'd3, 1'b0, "clr_nobyp");
            if (c == 5) begin
                push(0, 0, 32'd0, 1'b0, "clr_swept_x3");
                push(0, 1, 32'd20, 1'b0, "clr_partial_x20");
            end
            drain();
            tick();
        end
        chk("clr_ready_low_cycles", 64'(lowcnt), 64'd32);
        idle_in();
        for (int i = 0; i < 16; i++) begin
            rd(0, 2 * i); rd(1, 2 * i + 1);
            settle();
            push(0, 0, 32'h0, 1'b0, $sformatf("post_clr_x%0d", 2 * i));
            push(0, 1, 32'h0, 1'b0, $sformatf("post_clr_x%0d", 2 * i + 1));
            drain();
            tick();
        end

        // ---------------- reset mid-clear ----------------
        wr(0, 20, 32'h1234); wr(1, 25, 32'h55);
        tick(); idle_in();
        set_en = 1'b1; set_addr = 5'd25;
        tick(); idle_in();
        clr = 1'b1;
        tick(); idle_in();
        for (int c = 0; c < 10; c++) tick();
        rd(0, 20); rd(1, 25);
        settle();
        push(0, 0, 32'h1234, 1'b0, "midclr_x20_pre");
        push(0, 1, 32'h55, 1'b1, "midclr_x25_pre");
        drain();
        reset_n = 1'b0;
        #1;
        chk("midclr_rst_ready", 64'(ready), 64'd1);
        push(0, 0, 32'h0, 1'b0, "midclr_rst_x20");
        push(0, 1, 32'h0, 1'b0, "midclr_rst_x25");
        drain();
        tick();
        reset_n = 1'b1;
        tick();
        chk("midclr_after_ready", 64'(ready), 64'd1);

        // ---------------- 16-entry 4R/3W random traffic ----------------
        for (int r = 0; r < 16; r++) begin mreg[r] = '0; mbusy[r] = 1'b0; end
        for (int cyc = 0; cyc < 300; cyc++) begin
            logic [4:0]  wa[3];
            logic [31:0] wd[3];
            logic        we[3];
            logic        se;
            logic [4:0]  sa;
            for (int p = 0; p < 3; p++) begin
                we[p] = 1'($urandom_range(0, 1));
                wa[p] = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(16, 20)) : 5'($urandom_range(0, 7));
                wd[p] = $urandom;
                if (cyc == 0) begin we[p] = (p == 0); wa[p] = 5'd20; end
            end
            se = 1'($urandom_range(0, 1));
            sa = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(16, 20)) : 5'($urandom_range(0, 7));
            for (int p = 0; p < 3; p++) begin
                wr_en2[p] = we[p];
                wr_addr2[p*5 +: 5] = wa[p];
                wr_data2[p*32 +: 32] = wd[p];
            end
            set_en2 = se; set_addr2 = sa;
            for (int k = 0; k < 4; k++) begin
                logic [4:0]  a;
                logic [31:0] ed;
                logic        eb;
                logic        hit;
                a = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(16, 20)) : 5'($urandom_range(0, 7));
                if (cyc < 2 && k == 0) a = 5'd20;
                rd_addr2[k*5 +: 5] = a;
                ed = '0; eb = 1'b0;
                if (a != 0 && a < 16) begin
                    ed = mreg[a[3:0]]; eb = mbusy[a[3:0]]; hit = 1'b0;
                    for (int p = 0; p < 3; p++)
                        if (we[p] && wa[p] == a) begin ed = wd[p]; hit = 1'b1; end
                    if (hit && !(se && sa == a)) eb = 1'b0;
                end
                push(1, k, ed, eb, $sformatf("rnd_c%0d_p%0d_a%0d", cyc, k, a));
            end
            settle();
            drain();
            for (int p = 0; p < 3; p++)
                if (we[p] && wa[p] != 0 && wa[p] < 16) begin
                    mreg[wa[p][3:0]] = wd[p];
                    mbusy[wa[p][3:0]] = 1'b0;
                end
            if (se && sa != 0 && sa < 16) mbusy[sa[3:0]] = 1'b1;
            tick();
        end
        wr_en2 = '0; set_en2 = 1'b0;
        chk("p2_ready", 64'(ready2), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
